// File: rtl/therm_pkg.sv
// therm_pkg: shared widths, alarm defaults and FSM state encoding for the thermistor sampler
package therm_pkg;
  localparam int TEMP_W = 32;
  localparam int ADC_W = 4;
  localparam logic [TEMP_W-1:0] ALARM_SET_DEF = 60;
  localparam logic [TEMP_W-1:0] ALARM_CLR_DEF = 55;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_SETTLE, S_ACCUM, S_DONE} state_t;
endpackage

// File: rtl/therm_sample_ctrl_if.sv
// therm_sample_ctrl_if: ADC req/ack handshake plus the converter code/result link
interface therm_sample_ctrl_if;
  import therm_pkg::*;
  logic adc_req, adc_ack;
  logic [ADC_W-1:0] adc_data, v_therm;
  logic [TEMP_W-1:0] temp_therm;
  modport master (output adc_req, v_therm, input adc_ack, adc_data, temp_therm);
  modport slave (input adc_req, v_therm, output adc_ack, adc_data, temp_therm);
endinterface

// File: rtl/therm_period_timer.sv
// therm_period_timer: free-running 0..PERIOD-1 counter, held at 0 while disabled, tick at the top
module therm_period_timer #(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(PERIOD);
  logic [W-1:0] cnt;
  assign tick = enable && cnt == W'(PERIOD - 1);
  always_ff @(posedge clk)
    if (rst || !enable) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/therm_sample_ctrl.sv
// therm_sample_ctrl: periodic burst sampler that averages converter results and raises a hysteresis alarm
module therm_sample_ctrl import therm_pkg::*; #(
  parameter int PERIOD = 1000,
  parameter int SETTLE = 4,
  parameter int AVG_LOG2 = 2,
  parameter int ACK_TIMEOUT = 16,
  parameter logic [TEMP_W-1:0] ALARM_SET = ALARM_SET_DEF,
  parameter logic [TEMP_W-1:0] ALARM_CLR = ALARM_CLR_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic err_clr,
  therm_sample_ctrl_if.master adc,
  output logic [TEMP_W-1:0] temp_avg,
  output logic temp_valid,
  output logic alarm,
  output logic busy,
  output logic timeout_err,
  output logic overrun_err
);
  localparam int AW = TEMP_W + AVG_LOG2;
  localparam int SW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int CW = $clog2(SETTLE + 1);
  state_t state;
  logic tick, time_out, settled, last;
  logic [AW-1:0] acc, sum;
  logic [SW-1:0] sample_cnt;
  logic [TW-1:0] wait_cnt;
  logic [CW-1:0] settle_cnt;
  therm_period_timer #(.PERIOD(PERIOD)) u_timer (.clk(clk), .rst(rst), .enable(enable), .tick(tick));
  assign time_out = state == S_REQ && !adc.adc_ack && wait_cnt == TW'(ACK_TIMEOUT - 1);
  assign settled = settle_cnt == CW'(SETTLE - 1);
  assign last = sample_cnt == SW'((1 << AVG_LOG2) - 1);
  assign sum = acc + AW'(adc.temp_therm);
  assign adc.adc_req = state == S_REQ;
  assign busy = state != S_IDLE;
  // Per-state dwell counters restart whenever their state is left, so every entry starts from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      acc <= '0;
      sample_cnt <= '0;
      wait_cnt <= '0;
      settle_cnt <= '0;
      adc.v_therm <= '0;
      temp_avg <= '0;
      temp_valid <= 1'b0;
      alarm <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      temp_valid <= state == S_ACCUM && last;
      wait_cnt <= state == S_REQ ? wait_cnt + 1'b1 : '0;
      settle_cnt <= state == S_SETTLE ? settle_cnt + 1'b1 : '0;
      timeout_err <= time_out || (timeout_err && !err_clr);
      overrun_err <= (tick && busy) || (overrun_err && !err_clr);
      case (state)
        S_IDLE: if (tick) begin
          state <= S_REQ;
          acc <= '0;
          sample_cnt <= '0;
        end
        S_REQ: if (adc.adc_ack) begin
          adc.v_therm <= adc.adc_data;
          state <= S_SETTLE;
        end else if (time_out) state <= S_IDLE;
        S_SETTLE: if (settled) state <= S_ACCUM;
        S_ACCUM: begin
          acc <= sum;
          if (last) begin
            temp_avg <= sum[AW-1:AVG_LOG2];
            state <= S_DONE;
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
            state <= S_REQ;
          end
        end
        S_DONE: begin
          alarm <= temp_avg >= ALARM_SET ? 1'b1 : temp_avg < ALARM_CLR ? 1'b0 : alarm;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_therm_sample_ctrl.sv
// tb_therm_sample_ctrl: scoreboard bench; default instance for bursts/alarm/timeout/reset, PERIOD=20 instance for overrun
module tb_therm_sample_ctrl;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, err_clr = 1'b0, en_b = 1'b0, ack_en = 1'b1;
  logic [31:0] avg_a, avg_b;
  logic valid_a, alarm_a, busy_a, tmo_a, ovr_a;
  logic valid_b, alarm_b, busy_b, tmo_b, ovr_b;
  logic [31:0] tbl [4];
  logic [31:0] exp_q [$];
  logic exp_alarm = 1'b0, busy_prev = 1'b0;
  int tests = 0, errors = 0, cyc = 0, t_start = 0, k_a = 0, nb = 0;

  therm_sample_ctrl_if a();
  therm_sample_ctrl_if b();

  therm_sample_ctrl dut_a (.clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr), .adc(a),
    .temp_avg(avg_a), .temp_valid(valid_a), .alarm(alarm_a), .busy(busy_a),
    .timeout_err(tmo_a), .overrun_err(ovr_a));
  therm_sample_ctrl #(.PERIOD(20)) dut_b (.clk(clk), .rst(rst), .enable(en_b), .err_clr(1'b0), .adc(b),
    .temp_avg(avg_b), .temp_valid(valid_b), .alarm(alarm_b), .busy(busy_b),
    .timeout_err(tmo_b), .overrun_err(ovr_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC + converter model for instance a: acks on the first REQ cycle, code k+1, result tbl[k]
  initial begin
    a.adc_ack = 1'b0; a.adc_data = '0; a.temp_therm = '0;
    forever begin
      @(negedge clk);
      a.adc_ack = 1'b0;
      if (a.adc_req && ack_en) begin
        a.adc_ack = 1'b1;
        a.adc_data = 4'(k_a + 1);
        a.temp_therm = tbl[k_a];
        k_a = (k_a + 1) % 4;
      end
    end
  end

  // Instance b: ack in the 11th REQ cycle of every sample, constant result 40
  initial begin
    b.adc_ack = 1'b0; b.adc_data = '0; b.temp_therm = '0;
    forever begin
      @(negedge clk);
      b.adc_ack = 1'b0;
      if (b.adc_req) begin
        if (nb == 10) begin
          b.adc_ack = 1'b1; b.adc_data = 4'd1; b.temp_therm = 32'd40; nb = 0;
        end else nb++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy_a && !busy_prev) t_start = cyc;
      busy_prev = busy_a;
      if (valid_a) begin
        if (exp_q.size() == 0) check("spurious_valid", valid_a, 0);
        else begin
          check("avg", avg_a, exp_q.pop_front());
          check("latency", cyc - t_start, 24);
        end
      end
    end
  end

  task automatic check_reset();
    check("rst_req", a.adc_req, 0);
    check("rst_v_therm", a.v_therm, 0);
    check("rst_avg", avg_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_alarm", alarm_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_timeout", tmo_a, 0);
    check("rst_overrun", ovr_a, 0);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy_a && n < 1100) begin @(negedge clk); n++; end
    check("burst_start", busy_a, 1);
  endtask

  task automatic burst(input logic [31:0] t0, t1, t2, t3);
    logic [33:0] s;
    logic [31:0] e;
    int n = 0;
    tbl[0] = t0; tbl[1] = t1; tbl[2] = t2; tbl[3] = t3;
    s = 34'(t0) + 34'(t1) + 34'(t2) + 34'(t3);
    e = s[33:2];
    exp_q.push_back(e);
    exp_alarm = e >= 60 ? 1'b1 : e < 55 ? 1'b0 : exp_alarm;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy_a) && n < 1200) begin @(negedge clk); n++; end
    check("drain", exp_q.size(), 0);
    check("alarm", alarm_a, exp_alarm);
    check("busy_after", busy_a, 0);
  endtask

  initial begin
    int n, c1;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    enable = 1'b1;
    burst(30, 30, 30, 30);
    check("v_therm_last", a.v_therm, 4);
    burst(58, 62, 62, 58);
    burst(57, 57, 57, 57);
    burst(54, 54, 54, 54);
    burst(1, 2, 2, 2);
    burst(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // ack timeout: adc_req must stay up exactly ACK_TIMEOUT cycles
    ack_en = 1'b0;
    wait_busy();
    n = 0;
    while (a.adc_req && n < 40) begin n++; @(negedge clk); end
    check("req_cycles", n, 16);
    check("timeout_set", tmo_a, 1);
    check("timeout_idle", busy_a, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("timeout_clr", tmo_a, 0);
    check("overrun_a", ovr_a, 0);
    ack_en = 1'b1;
    // reset during SETTLE of the second sample
    tbl[0] = 10; tbl[1] = 20; tbl[2] = 30; tbl[3] = 40;
    wait_busy();
    repeat (8) @(negedge clk);
    check("mid_v_therm", a.v_therm, 2);
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    k_a = 0;
    exp_alarm = 1'b0;
    burst(61, 61, 61, 61);
    // overrun on the PERIOD=20 instance with slow acks
    en_b = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!valid_b && n < 300);
    c1 = cyc;
    check("b_valid1", valid_b, 1);
    check("b_avg1", avg_b, 40);
    check("b_overrun", ovr_b, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!valid_b && n < 300);
    check("b_valid2", valid_b, 1);
    check("b_avg2", avg_b, 40);
    check("b_gap", cyc - c1, 80);
    check("b_timeout", tmo_b, 0);
    en_b = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/therm_sample_ctrl.md
Name: therm_sample_ctrl

Overview:
Periodic sampling sequencer for the thermistor voltage-to-temperature converter. On each period tick it runs a burst of 2^AVG_LOG2 ADC reads via a req/ack handshake. For each read it drives the 4-bit code onto the converter input, waits a fixed settle time, then accumulates the converter's 32-bit temperature. At the end of the burst it publishes the truncated average with a one-cycle valid pulse, plus a hysteresis over-temperature alarm. Sits between the ADC front end and the converter; downstream logic consumes temp_avg/temp_valid/alarm.

Parameters:
PERIOD, 1000, clock cycles between burst starts (>= 2)
SETTLE, 4, cycles the converter output is allowed to settle after v_therm changes (>= 1)
AVG_LOG2, 2, log2 of samples per burst (0..4)
ACK_TIMEOUT, 16, max cycles adc_req may wait for adc_ack
ALARM_SET, 60, temp_avg >= this sets alarm
ALARM_CLR, 55, temp_avg < this clears alarm (ALARM_CLR <= ALARM_SET)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  allows period counting/new bursts
err_clr  in  1  clears sticky error flags
adc_req  out  1  request ADC sample
adc_ack  in  1  ADC data valid; completes the handshake
adc_data  in  4  ADC code, sampled when adc_req && adc_ack
v_therm  out  4  registered code to converter input
temp_therm  in  32  converter result, unsigned
temp_avg  out  32  averaged temperature, unsigned
temp_valid  out  1  one-cycle pulse; temp_avg updated this cycle
alarm  out  1  over-temperature, hysteresis
busy  out  1  high whenever state != IDLE
timeout_err  out  1  sticky: ack timeout occurred
overrun_err  out  1  sticky: tick arrived while busy

Behaviour:
- Reset, on any rst edge including mid-burst: state IDLE. adc_req=0, v_therm=0, temp_avg=0, temp_valid=0, alarm=0, busy=0, timeout_err=0, overrun_err=0. Period counter, accumulator and sample counter = 0.
- Period timer: counts 0..PERIOD-1 while enable=1 and wraps. Tick = one-cycle pulse at count PERIOD-1. enable=0 holds the count at 0. An in-progress burst still completes.
- States: IDLE, REQ, SETTLE, ACCUM, DONE.
- IDLE: on tick, go to REQ. Clear the accumulator and sample counter.
- REQ: adc_req=1. If adc_ack this cycle: v_therm <= adc_data, go to SETTLE, adc_req=0 next cycle. After ACK_TIMEOUT consecutive REQ cycles without ack: timeout_err <= 1, go to IDLE. No temp_valid is produced and the partial accumulator is discarded.
- SETTLE: stay exactly SETTLE cycles, then go to ACCUM.
- ACCUM, one cycle: acc <= acc + temp_therm. acc is 32+AVG_LOG2 bits, so it never overflows. If sample_cnt == 2^AVG_LOG2-1, go to DONE; else sample_cnt++ and go to REQ.
- DONE, one cycle:
  - temp_avg = acc >> AVG_LOG2 (truncation) and temp_valid=1, both visible this cycle (registered on the ACCUM->DONE edge).
  - alarm <= 1 if temp_avg >= ALARM_SET; alarm <= 0 if temp_avg < ALARM_CLR; otherwise alarm holds. Compares are unsigned.
  - Next state is IDLE.
- Latency with zero-wait acks: each sample takes SETTLE+2 cycles. DONE occurs 2^AVG_LOG2*(SETTLE+2) cycles after REQ entry. Default: 24.
- A tick in any state other than IDLE is dropped and sets overrun_err. No queuing.
- err_clr clears both sticky flags. If err_clr coincides with a new error event, the set wins.
- temp_avg and alarm hold their values between bursts.
- v_therm holds its last code until the next ack.

Decomposition:
- Package therm_pkg:
  - state enum (IDLE, REQ, SETTLE, ACCUM, DONE)
  - TEMP_W=32, ADC_W=4
  - default ALARM_SET/ALARM_CLR constants
- One sub-module: therm_period_timer (PERIOD counter, enable hold, tick output).
- FSM, accumulator and alarm logic stay in the top module.

Test Plan:
1. Defaults, ack on first REQ cycle, temp_therm=30 constant -> temp_valid exactly once, 24 cycles after REQ entry, temp_avg=30, alarm=0, busy low after DONE.
2. Per-sample temp_therm 58,62,62,58 -> temp_avg=60, alarm=1. Next burst at 57 -> alarm stays 1. Next burst at 54 -> alarm=0.
3. Truncation: samples 1,2,2,2 -> temp_avg=1. Samples 0xFFFFFFFF x4 -> temp_avg=0xFFFFFFFF (no overflow).
4. adc_ack never asserted -> adc_req high for 16 cycles, then low. timeout_err=1, no temp_valid, state IDLE. err_clr pulse -> timeout_err=0.
5. PERIOD=20, ack delayed 10 cycles per sample -> second tick arrives while busy. overrun_err=1, that burst is skipped, the following tick runs normally.
6. rst asserted during SETTLE of sample 2 -> next cycle all outputs at reset values. No temp_valid until a full new burst completes after the next tick.
